// File: rtl/nnrv_pkg.sv
// Shared definitions for the NNRV memory arbiter: owner-tag encoding for
// routing read responses, the fetch starvation limit and the grant bit order.
package nnrv_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } own_t;

  // Fetch wins the next contention once it has been denied this many times.
  localparam logic [1:0] STARV_LIMIT = 2'd3;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_IF = 0;
  localparam int GNT_D  = 1;

endpackage

// File: rtl/nnrv_arb_pick.sv
// Grant selection between the fetch and data requesters.
// Default build: data has priority unless the fetch starvation count has
// reached STARV_LIMIT. With NNRV_MEM_ARB_RR_EN defined, contention goes to
// whichever requester was not granted last.
module nnrv_arb_pick
  import nnrv_pkg::*;
(
  input  logic       i_req_if,
  input  logic       i_req_d,
`ifdef NNRV_MEM_ARB_RR_EN
  input  logic       i_last_d,
`else
  input  logic [1:0] i_starv_cnt,
`endif
  output logic [1:0] o_gnt
);

  logic fav_if;

  // Decide who wins a tie under the active policy.
  always_comb begin
`ifdef NNRV_MEM_ARB_RR_EN
    fav_if = i_last_d;
`else
    fav_if = (i_starv_cnt == STARV_LIMIT);
`endif
  end

  // One-hot grant: a lone requester always wins, ties go to the favoured one.
  always_comb begin
    o_gnt = 2'b00;
    if (i_req_if && i_req_d) begin
      if (fav_if) o_gnt[GNT_IF] = 1'b1;
      else        o_gnt[GNT_D]  = 1'b1;
    end else if (i_req_if) begin
      o_gnt[GNT_IF] = 1'b1;
    end else if (i_req_d) begin
      o_gnt[GNT_D] = 1'b1;
    end
  end

endmodule

// File: rtl/nnrv_mem_arb.sv
// Single-port RAM arbiter between instruction fetch and data load/store.
// Grants are combinational and issue the RAM command in the same cycle; a
// registered owner tag routes the read data returned one cycle later.
// Optional macro NNRV_MEM_ARB_RR_EN selects round-robin arbitration instead
// of data-priority with a fetch starvation guard.
module nnrv_mem_arb
  import nnrv_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int MASK_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_if_req,
  input  logic [XLEN-1:0]       i_if_addr,
  input  logic                  i_if_flush,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [XLEN-1:0]       o_if_rdata,
  input  logic                  i_d_rd_en,
  input  logic                  i_d_wr_en,
  input  logic [XLEN-1:0]       i_d_addr,
  input  logic [MASK_WIDTH-1:0] i_d_mask,
  input  logic [XLEN-1:0]       i_d_wdata,
  output logic                  o_d_gnt,
  output logic                  o_d_rvalid,
  output logic [XLEN-1:0]       o_d_rdata,
  output logic                  o_ram_rd_en,
  output logic                  o_ram_wr_en,
  output logic [XLEN-1:0]       o_ram_addr,
  output logic [MASK_WIDTH-1:0] o_ram_mask,
  output logic [XLEN-1:0]       o_ram_wr_data,
  input  logic [XLEN-1:0]       i_ram_rd_data
);

  logic       req_if;
  logic       req_d;
  logic       d_is_wr;
  logic [1:0] pick_gnt;
  logic       gnt_if;
  logic       gnt_d;
  own_t       owner_nxt;
  own_t       owner_p1;

  // A flush kills the fetch request outright; read+write together is a write.
  assign req_if  = i_if_req & ~i_if_flush;
  assign req_d   = i_d_rd_en | i_d_wr_en;
  assign d_is_wr = i_d_wr_en;

`ifdef NNRV_MEM_ARB_RR_EN
  logic last_d_q;

  // Remember which requester got the most recent grant (reset = fetch).
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              last_d_q <= 1'b0;
    else if (gnt_if || gnt_d)  last_d_q <= gnt_d;
  end
`else
  logic [1:0] starv_cnt;

  // Count consecutive denied fetch cycles, saturating at the limit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                       starv_cnt <= 2'd0;
    else if (!i_if_req || gnt_if)       starv_cnt <= 2'd0;
    else if (starv_cnt != STARV_LIMIT)  starv_cnt <= starv_cnt + 2'd1;
  end
`endif

  nnrv_arb_pick u_pick (
    .i_req_if    (req_if),
    .i_req_d     (req_d),
`ifdef NNRV_MEM_ARB_RR_EN
    .i_last_d    (last_d_q),
`else
    .i_starv_cnt (starv_cnt),
`endif
    .o_gnt       (pick_gnt)
  );

  // Nothing is granted while reset is held.
  assign gnt_if   = pick_gnt[GNT_IF] & i_rst_n;
  assign gnt_d    = pick_gnt[GNT_D]  & i_rst_n;
  assign o_if_gnt = gnt_if;
  assign o_d_gnt  = gnt_d;

  // Steer the granted requester onto the RAM port; idle port is all zero.
  always_comb begin
    o_ram_rd_en   = 1'b0;
    o_ram_wr_en   = 1'b0;
    o_ram_addr    = '0;
    o_ram_mask    = '0;
    o_ram_wr_data = '0;
    if (gnt_if) begin
      o_ram_rd_en = 1'b1;
      o_ram_addr  = i_if_addr;
      o_ram_mask  = '1;
    end else if (gnt_d) begin
      o_ram_rd_en   = ~d_is_wr;
      o_ram_wr_en   = d_is_wr;
      o_ram_addr    = i_d_addr;
      o_ram_mask    = i_d_mask;
      o_ram_wr_data = i_d_wdata;
    end
  end

  // Tag the read issued this cycle so its data can be routed next cycle.
  always_comb begin
    owner_nxt = OWN_NONE;
    if (gnt_if)                owner_nxt = OWN_IF;
    else if (gnt_d && !d_is_wr) owner_nxt = OWN_D;
  end

  // ---- stage p1: response owner, aligned with i_ram_rd_data ----
  // Owner tag register; reset drops any outstanding response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) owner_p1 <= OWN_NONE;
    else          owner_p1 <= owner_nxt;
  end

  // A flush in the response cycle discards the returning fetch data.
  assign o_if_rvalid = (owner_p1 == OWN_IF) & ~i_if_flush;
  assign o_d_rvalid  = (owner_p1 == OWN_D);
  assign o_if_rdata  = o_if_rvalid ? i_ram_rd_data : '0;
  assign o_d_rdata   = o_d_rvalid  ? i_ram_rd_data : '0;

endmodule

// File: doc/nnrv_mem_arb.md
NNRV_MEM_ARB -- requirements
Module: nnrv_mem_arb

Interface
REQ-001 SHALL have parameter XLEN, default 64, data/address width.
REQ-002 SHALL have parameter MASK_WIDTH, default 8, byte-mask width.
REQ-003 SHALL have ports: i_clk  in  1  clock, rising edge; i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have: i_if_req  in  1  fetch read request; i_if_addr  in  XLEN  fetch address; i_if_flush  in  1  cancel fetch request and in-flight fetch response.
REQ-005 SHALL have: o_if_gnt  out  1  fetch accepted; o_if_rvalid  out  1  fetch data valid; o_if_rdata  out  XLEN  fetch data.
REQ-006 SHALL have: i_d_rd_en  in  1  data read request; i_d_wr_en  in  1  data write request; i_d_addr  in  XLEN; i_d_mask  in  MASK_WIDTH; i_d_wdata  in  XLEN.
REQ-007 SHALL have: o_d_gnt  out  1  data accepted; o_d_rvalid  out  1  load data valid; o_d_rdata  out  XLEN  load data.
REQ-008 SHALL have single RAM port: o_ram_rd_en, o_ram_wr_en  out  1; o_ram_addr  out  XLEN; o_ram_mask  out  MASK_WIDTH; o_ram_wr_data  out  XLEN; i_ram_rd_data  in  XLEN, valid one cycle after o_ram_rd_en.

Function
REQ-009 Requester SHALL hold request and payload stable until its gnt is high; grant is combinational, same cycle as RAM command.
REQ-010 At most one of o_if_gnt, o_d_gnt SHALL be high per cycle; i_d_rd_en and i_d_wr_en both high SHALL be treated as write only.
REQ-011 Granted requester's addr/mask (and wdata, wr_en for data) SHALL drive RAM port that cycle; with no grant all RAM enables SHALL be 0.
REQ-012 Fetch grants SHALL drive o_ram_mask all-ones.
REQ-013 Back-to-back grants SHALL be allowed every cycle; throughput one access per cycle.
REQ-014 A registered owner tag SHALL route read response: o_*_rvalid high exactly one cycle after a read grant to that requester; writes produce no rvalid.
REQ-015 o_if_rdata, o_d_rdata SHALL equal i_ram_rd_data when respective rvalid high, zero otherwise.
REQ-016 i_if_flush high SHALL force o_if_gnt low that cycle and suppress o_if_rvalid for a fetch granted in the previous cycle.
REQ-017 Default policy: data request wins over fetch.
REQ-018 Starvation guard: 2-bit counter increments each cycle fetch is requesting and denied; at value 3 fetch SHALL win next contention; counter clears on fetch grant or when i_if_req low.

Reset
REQ-019 While i_rst_n low: all gnt, rvalid, RAM enables 0; rdata 0; owner tag, starvation counter, last-grant register cleared to 0.
REQ-020 Reset asserted mid-access SHALL drop the outstanding response; no rvalid after reset release without a new grant.

Configuration
REQ-021 Macro NNRV_MEM_ARB_RR_EN defined: REQ-017/018 replaced by round-robin; on contention the requester not granted last wins; last-grant reset value = fetch, so data wins first contention.
REQ-022 Macro undefined: fixed priority with starvation guard per REQ-017/018; round-robin logic absent.

Structure
REQ-023 Shared package nnrv_pkg SHALL hold owner-tag encoding (OWN_NONE, OWN_IF, OWN_D) and starvation limit constant (3).
REQ-024 Grant selection SHALL be one sub-module nnrv_arb_pick (two requests, policy state in, one-hot grant out); remainder in nnrv_mem_arb.

Verification
REQ-025 Fetch only, addr 0x1000, RAM returns 0x00000013 -> o_if_gnt same cycle, o_if_rvalid next cycle with 0x13, o_ram_mask 0xFF.
REQ-026 Fetch and data read contend continuously, fixed priority -> data granted cycles 0-2, fetch granted cycle 3, data cycle 4.
REQ-027 Data write addr 0x2008 mask 0x0F data 0xDEADBEEF -> o_ram_wr_en 1 one cycle, wdata/mask passed, no o_d_rvalid.
REQ-028 Fetch granted cycle N, i_if_flush cycle N+1 -> o_if_rvalid 0 at N+1; concurrent data read in N+1 granted, o_d_rvalid at N+2.
REQ-029 i_rst_n low the cycle after a data read grant -> o_d_rvalid stays 0; post-release, first access behaves per REQ-025.
REQ-030 NNRV_MEM_ARB_RR_EN defined, both requesting continuously -> grants alternate D, IF, D, IF starting with data.
